if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised IF/ID pipeline register, the next generation of the fetch/decode boundary register. It carries PC, instruction and branch-predictor hit from fetch to decode through a two-entry skid buffer with valid/ready handshakes. It supports decode-side stalls without combinational ready paths, and a flush that squashes in-flight instructions into NOP bubbles. It sits between the fetch stage (PC + instruction memory + predictor) and the decode/register-file stage.

## Interface
- PC_W, 32, width of the PC field
- INSN_W, 32, width of the instruction field
- NOP_INSN, all-zero (INSN_W bits), instruction value driven whenever no valid instruction is present
- CNT_W, 16, width of the saturating bubble counter
- clk  in  1  clock; all state updates on the falling edge of clk
- rst  in  1  synchronous active-high reset, sampled on the falling edge of clk
- in_valid  in  1  fetch presents a valid instruction
- in_ready  out  1  register can accept; registered; equals !skid_valid and is 0 while rst=1
- in_pc  in  PC_W  next-PC value from fetch
- in_insn  in  INSN_W  fetched instruction
- in_hit  in  1  predictor hit flag
- flush  in  1  squash all held and incoming instructions (mispredict or jump)
- out_valid  out  1  main entry holds a valid instruction
- out_ready  in  1  decode accepts (de-asserted by hazard unit on stall)
- out_pc  out  PC_W  held PC
- out_insn  out  INSN_W  held instruction; NOP_INSN when out_valid=0
- out_hit  out  1  held hit flag; 0 when out_valid=0
- bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

## Operation
- Two entries: main (drives out_*) and skid (holds one overflow beat); each has a valid bit.
- Accept: in_valid & in_ready. Fire: out_valid & out_ready.
- Update priority, highest first: rst, flush, normal flow.
- rst: main_valid=0, skid_valid=0, out_pc=0, out_insn=NOP_INSN, out_hit=0, bubble_cnt=0.
- flush: main_valid=0, skid_valid=0, out_insn=NOP_INSN, out_hit=0; out_pc holds; any beat offered that cycle is dropped (not accepted, even if in_ready=1); bubble_cnt still updates.
- Normal flow when main empty or firing: if skid_valid, main<=skid, skid_valid<=0; else if accept, main<=input; else main_valid<=0 and out_insn<=NOP_INSN, out_hit<=0.
- Normal flow when main valid and not firing: if accept, skid<=input, skid_valid<=1; main holds.
- A beat is never accepted while skid_valid=1, so skid never overflows; no beat is duplicated or reordered.
- bubble_cnt increments by 1 when out_ready=1 and out_valid=0, saturating at 2^CNT_W-1; it never wraps.

## Timing
- Latency: a beat accepted at falling edge N is on out_* immediately after edge N when main was empty or firing; otherwise it appears after the edge on which main fires.
- Throughput: one beat per cycle with out_ready held high.
- in_ready depends only on registered state; there is no combinational path from out_ready or flush to in_ready.
- After a stall begins, at most one further beat is absorbed; in_ready drops after that edge.
- flush takes effect at the edge where it is sampled; out_valid=0 from then on. in_ready=1 on the following cycle.
- rst asserted mid-stream discards both entries at that edge; in_ready=1 on the first cycle after rst deasserts.
- flush and rst together behave as rst.

## Structure
- Shared pipeline package holds NOP_INSN and the IF/ID payload struct (pc, insn, hit) typedef, reused by the ID/EX register.
- One natural sub-module: pipe_skid_buffer, generic over payload width, holding the main/skid entries and handshake logic. The top adds flush-to-NOP payload forcing and bubble_cnt.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_insn=NOP_INSN, out_pc=0, in_ready=0 during rst, in_ready=1 after, bubble_cnt=0.
- Streaming: 4 beats at pc 0x4,0x8,0xC,0x10 with out_ready=1 -> each appears one edge after acceptance, in order, with no gaps.
- Stall: drop out_ready while streaming -> exactly one extra beat is absorbed and in_ready falls. On release, beats drain in order with no loss or duplicate.
- Flush under stall: main=0x8 and skid=0xC held; assert flush with in_valid=1 pc 0x10 -> out_valid=0, out_insn=NOP_INSN, out_hit=0, and beat 0x10 is dropped.
- Bubbles: out_ready=1 and in_valid=0 for 5 cycles -> bubble_cnt=5. With CNT_W=2, run 6 cycles -> saturates at 3.
- Random valid/ready/flush for 10k cycles against a reference queue model -> beats out equal beats in minus flushed beats, in order.

Source files
------------

// File: rtl/if_id_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg_pkg
// Shared pipeline package for the fetch/decode boundary.
// Holds the default field widths, the NOP encoding used for bubbles, and the
// IF/ID payload struct (pc, insn, hit). The ID/EX register reuses the same
// payload layout, so changes here ripple into both pipeline registers.
// ---------------------------------------------------------------------------
package if_id_skid_reg_pkg;

  localparam int IF_ID_PC_W   = 32;
  localparam int IF_ID_INSN_W = 32;
  localparam int IF_ID_CNT_W  = 16;

  // All-zero instruction doubles as the pipeline bubble.
  localparam logic [IF_ID_INSN_W-1:0] IF_ID_NOP_INSN = '0;

  typedef struct packed {
    logic [IF_ID_PC_W-1:0]   pc;
    logic [IF_ID_INSN_W-1:0] insn;
    logic                    hit;
  } if_id_payload_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// ---------------------------------------------------------------------------
// pipe_skid_buffer
// Generic two-entry skid buffer with valid/ready handshakes. The main entry
// drives the output; the skid entry catches the single beat that arrives in
// the cycle a stall begins, so in_ready can be a plain register.
// All state updates on the falling edge of clk.
//
// Ports:
//   clk, rst         clock (falling edge), synchronous active-high reset
//   flush            drops both entries and any beat offered this cycle
//   in_valid/ready   upstream handshake; in_ready is registered
//   in_data          upstream payload, W bits
//   out_valid/ready  downstream handshake; out_valid is the main valid bit
//   out_data         main entry payload (holds its last value when empty)
// ---------------------------------------------------------------------------
module pipe_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         ready_q;

  logic accept;
  logic main_valid_n;
  logic skid_valid_n;
  logic load_main_from_skid;
  logic load_main_from_in;
  logic load_skid;

  // A beat offered during flush is dropped even when ready is high.
  assign accept = in_valid & ready_q & ~flush;

  // Next-state decision. Main may take a new beat whenever it is empty or
  // firing; the skid entry always drains first to keep beats in order.
  always_comb begin
    main_valid_n        = main_valid;
    skid_valid_n        = skid_valid;
    load_main_from_skid = 1'b0;
    load_main_from_in   = 1'b0;
    load_skid           = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        load_main_from_skid = 1'b1;
        main_valid_n        = 1'b1;
        skid_valid_n        = 1'b0;
      end else if (accept) begin
        load_main_from_in = 1'b1;
        main_valid_n      = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  // State registers. ready is derived from the next skid occupancy so it is
  // a pure flop output with no path back from out_ready or flush.
  always_ff @(negedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      ready_q    <= ~skid_valid_n;
      if (load_main_from_skid) begin
        main_data <= skid_data;
      end else if (load_main_from_in) begin
        main_data <= in_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline register built on a two-entry skid buffer. Carries PC,
// instruction and predictor hit from fetch to decode. Adds NOP forcing of the
// payload whenever no valid instruction is held (after flush, reset or a
// drained buffer) and a saturating bubble counter.
// State updates on the falling edge of clk.
//
// Ports:
//   clk, rst                     clock (falling edge), sync active-high reset
//   in_valid, in_ready           fetch handshake; in_ready is registered
//   in_pc, in_insn, in_hit       fetch payload
//   flush                        squash held and incoming instructions
//   out_valid, out_ready         decode handshake
//   out_pc, out_insn, out_hit    held payload; insn=NOP and hit=0 when empty
//   bubble_cnt                   saturating count of ready-but-empty cycles
// ---------------------------------------------------------------------------
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int                PC_W     = IF_ID_PC_W,
  parameter int                INSN_W   = IF_ID_INSN_W,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(IF_ID_NOP_INSN),
  parameter int                CNT_W    = IF_ID_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              in_hit,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INSN_W-1:0] out_insn,
  output logic              out_hit,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
    logic              hit;
  } payload_t;

  localparam int PAY_W = $bits(payload_t);

  payload_t in_pay;
  payload_t main_pay;
  logic     main_valid;

  always_comb begin
    in_pay      = '0;
    in_pay.pc   = in_pc;
    in_pay.insn = in_insn;
    in_pay.hit  = in_hit;
  end

  pipe_skid_buffer #(
    .W(PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (main_valid),
    .out_ready (out_ready),
    .out_data  (main_pay)
  );

  // The stored payload is left untouched when main empties, so the PC holds
  // its last value; insn and hit are masked to a bubble instead.
  always_comb begin
    out_pc   = main_pay.pc;
    out_insn = NOP_INSN;
    out_hit  = 1'b0;
    if (main_valid) begin
      out_insn = main_pay.insn;
      out_hit  = main_pay.hit;
    end
  end

  assign out_valid = main_valid;

  // Counts decode cycles that found nothing to consume; sticks at all-ones.
  always_ff @(negedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && !main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid_reg
// Directed and random checks of the IF/ID skid register. A second instance
// with a 2-bit bubble counter shares all inputs to exercise saturation.
// ---------------------------------------------------------------------------
module tb_if_id_skid_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        hit;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_hit, out_ready;
  logic [31:0] in_pc, in_insn;

  logic        in_ready, out_valid, out_hit;
  logic [31:0] out_pc, out_insn;
  logic [15:0] bubble_cnt;

  logic        in_ready2, out_valid2, out_hit2;
  logic [31:0] out_pc2, out_insn2;
  logic [1:0]  bubble_cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state for the random phase
  beat_t mq[$];
  logic  m_ready;
  logic [31:0] m_hold_pc;
  int    m_bub;
  int    beats_in, beats_out, beats_flushed;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_insn(in_insn), .in_hit(in_hit), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_insn(out_insn), .out_hit(out_hit), .bubble_cnt(bubble_cnt)
  );

  if_id_skid_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_pc(in_pc), .in_insn(in_insn), .in_hit(in_hit), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2),
    .out_insn(out_insn2), .out_hit(out_hit2), .bubble_cnt(bubble_cnt2)
  );

  function automatic logic [31:0] mkInsn(input logic [31:0] pc);
    return {16'h0013, pc[15:0]};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the falling edge update state, then
  // return on the rising edge where outputs are stable.
  task automatic applyStimulus(input logic r, input logic fl, input logic iv,
                               input logic [31:0] pc, input logic [31:0] insn,
                               input logic hit, input logic ordy);
    rst = r; flush = fl; in_valid = iv; in_pc = pc;
    in_insn = insn; in_hit = hit; out_ready = ordy;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic expectBeat(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_pc"}, out_pc, pc);
    checkOutput({tag, "_insn"}, out_insn, mkInsn(pc));
    checkOutput({tag, "_hit"}, out_hit, pc[2]);
  endtask

  task automatic expectEmpty(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_pc"}, out_pc, pc);
    checkOutput({tag, "_insn"}, out_insn, 32'h0);
    checkOutput({tag, "_hit"}, out_hit, 1'b0);
  endtask

  // Shorthand for directed beats whose insn/hit derive from pc.
  task automatic beat(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    applyStimulus(1'b0, fl, iv, pc, mkInsn(pc), pc[2], ordy);
  endtask

  // Reference update for one edge of the random phase.
  task automatic modelStep(input logic fl, input logic iv, input beat_t b, input logic ordy);
    if (ordy && mq.size() == 0) m_bub++;
    if (fl) begin
      beats_flushed += mq.size();
      mq.delete();
      m_ready = 1'b1;
    end else begin
      if (mq.size() > 0 && ordy) begin
        void'(mq.pop_front());
        beats_out++;
      end
      if (iv && m_ready) begin
        mq.push_back(b);
        beats_in++;
      end
      m_ready = (mq.size() < 2);
    end
    if (mq.size() > 0) m_hold_pc = mq[0].pc;
  endtask

  initial begin
    // Reset held two cycles with a beat offered
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, mkInsn(32'h100), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, mkInsn(32'h100), 1'b0, 1'b0);
    expectEmpty("rst", 32'h0);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_bubble", bubble_cnt, 16'd0);
    beat(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
    checkOutput("post_rst_valid", out_valid, 1'b0);

    // Streaming, one beat per edge
    beat(1'b0, 1'b1, 32'h4, 1'b1);  expectBeat("s4", 32'h4);
    beat(1'b0, 1'b1, 32'h8, 1'b1);  expectBeat("s8", 32'h8);
    beat(1'b0, 1'b1, 32'hC, 1'b1);  expectBeat("sC", 32'hC);
    beat(1'b0, 1'b1, 32'h10, 1'b1); expectBeat("s10", 32'h10);
    checkOutput("s_in_ready", in_ready, 1'b1);

    // Stall: one extra beat absorbed into skid, then ready drops
    beat(1'b0, 1'b1, 32'h14, 1'b0);
    expectBeat("st1", 32'h10);
    checkOutput("st1_in_ready", in_ready, 1'b0);
    beat(1'b0, 1'b1, 32'h18, 1'b0);
    expectBeat("st2", 32'h10);
    checkOutput("st2_in_ready", in_ready, 1'b0);
    beat(1'b0, 1'b1, 32'h18, 1'b1);
    expectBeat("rel1", 32'h14);
    checkOutput("rel1_in_ready", in_ready, 1'b1);
    beat(1'b0, 1'b1, 32'h18, 1'b1);
    expectBeat("rel2", 32'h18);
    beat(1'b0, 1'b0, 32'h0, 1'b1);
    expectEmpty("drain", 32'h18);

    // Flush with main=0x8 and skid=0xC, beat 0x10 offered
    beat(1'b0, 1'b1, 32'h8, 1'b0);
    beat(1'b0, 1'b1, 32'hC, 1'b0);
    expectBeat("fl_main", 32'h8);
    checkOutput("fl_pre_in_ready", in_ready, 1'b0);
    beat(1'b1, 1'b1, 32'h10, 1'b0);
    expectEmpty("fl", 32'h8);
    checkOutput("fl_in_ready", in_ready, 1'b1);
    beat(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("fl_dropped_valid", out_valid, 1'b0);

    // flush together with rst behaves as rst
    beat(1'b0, 1'b1, 32'h40, 1'b0);
    expectBeat("fr_fill", 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h44, mkInsn(32'h44), 1'b1, 1'b0);
    expectEmpty("fr", 32'h0);
    checkOutput("fr_in_ready", in_ready, 1'b0);
    checkOutput("fr_bubble", bubble_cnt, 16'd0);
    beat(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fr_post_in_ready", in_ready, 1'b1);

    // Bubbles: 5 empty cycles, then a 6th; 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bub5", bubble_cnt, 16'd5);
    checkOutput("bub5_sat", bubble_cnt2, 2'd3);
    beat(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bub6", bubble_cnt, 16'd6);
    checkOutput("bub6_sat", bubble_cnt2, 2'd3);

    // Random valid/ready/flush against the queue model
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    mq.delete();
    m_ready = 1'b0; m_hold_pc = 32'h0; m_bub = 0;
    beats_in = 0; beats_out = 0; beats_flushed = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      beat_t b;
      logic iv, ordy, fl;
      iv     = ($urandom_range(99) < 70);
      ordy   = ($urandom_range(99) < 60);
      fl     = ($urandom_range(99) < 2);
      b.pc   = 32'(cyc) << 2;
      b.insn = $urandom;
      b.hit  = $urandom_range(1);
      applyStimulus(1'b0, fl, iv, b.pc, b.insn, b.hit, ordy);
      modelStep(fl, iv, b, ordy);
      checkOutput("r_in_ready", in_ready, m_ready);
      checkOutput("r_valid", out_valid, mq.size() > 0);
      checkOutput("r_pc", out_pc, m_hold_pc);
      checkOutput("r_insn", out_insn, (mq.size() > 0) ? mq[0].insn : 32'h0);
      checkOutput("r_hit", out_hit, (mq.size() > 0) ? mq[0].hit : 1'b0);
      checkOutput("r_bubble", bubble_cnt, 16'(m_bub));
      checkOutput("r_bubble_sat", bubble_cnt2, (m_bub > 3) ? 2'd3 : 2'(m_bub));
    end
    checkOutput("r_conservation", beats_out + beats_flushed + mq.size(), beats_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
